// File: rtl/serial_adder_lab6.sv
// Multi-cycle adder: adds WIDTH-bit operands BITS_PER_CYCLE bits per clock, N+1 cycles per operation with start/done handshake.
// Optional subtract mode (sub port, A + ~B + 1) is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder_lab6 #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             Overflow
);

  localparam int unsigned N     = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  if ((WIDTH < 2) || ((WIDTH % BITS_PER_CYCLE) != 0)) begin : g_bad_cfg
    $error("serial_adder_lab6: WIDTH must be >= 2 and divisible by BITS_PER_CYCLE");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   a_q, b_q, res_q, sum_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               carry_q, busy_q, done_q, cout_q, ovf_q;

  logic [BITS_PER_CYCLE-1:0] chunk_sum;
  logic                      chunk_cout, chunk_cmsb, c;
  logic [WIDTH-1:0]          res_d, b_start;
  logic                      cin_start;

`ifdef SERIAL_ADDER_SUB_EN
  assign b_start   = sub ? ~B : B;
  assign cin_start = sub;
`else
  assign b_start   = B;
  assign cin_start = 1'b0;
`endif

  // Ripple through the current chunk; chunk_cmsb keeps the carry into the chunk's top bit for overflow.
  always_comb begin
    chunk_sum  = '0;
    chunk_cmsb = 1'b0;
    c          = carry_q;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      chunk_cmsb   = c;
      chunk_sum[i] = a_q[i] ^ b_q[i] ^ c;
      c            = (a_q[i] & b_q[i]) | (c & (a_q[i] ^ b_q[i]));
    end
    chunk_cout = c;
  end

  assign res_d = WIDTH'({chunk_sum, res_q} >> BITS_PER_CYCLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          a_q     <= a_q >> BITS_PER_CYCLE;
          b_q     <= b_q >> BITS_PER_CYCLE;
          res_q   <= res_d;
          carry_q <= chunk_cout;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            sum_q   <= res_d;
            cout_q  <= chunk_cout;
            ovf_q   <= chunk_cmsb ^ chunk_cout;
          end
        end
        default: begin
          // IDLE and DONE both accept a new start, giving back-to-back operation.
          done_q <= 1'b0;
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            a_q     <= A;
            b_q     <= b_start;
            carry_q <= cin_start;
            cnt_q   <= '0;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign Sum      = sum_q;
  assign Carry    = cout_q;
  assign Overflow = ovf_q;

endmodule
